// File: rtl/demux_1to8_staged.sv
// One-to-eight registered demultiplexer with a one-entry output register and valid/ready per channel.
// Optional accepted-transfer counter enabled by defining DEMUX_ACCEPT_COUNT_EN.
module demux_1to8_staged #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           select,
  input  logic [WIDTH-1:0]     in_data,
  output logic [7:0]           out_valid,
  input  logic [7:0]           out_ready,
  output logic [8*WIDTH-1:0]   out_data,
  output logic                 busy,
  output logic [15:0]          accept_count
);

  // Handshake: a word moves when valid and ready are both high at a rising edge.
  // in_ready never looks at in_valid; a channel drains when out_valid[i] & out_ready[i].
  // Each bit of valid_q is that channel's EMPTY(0)/FULL(1) state and is visible on out_valid.
  logic [7:0]         valid_q, valid_d;
  logic [8*WIDTH-1:0] data_q, data_d;
  logic               accept;

  assign in_ready = ~valid_q[select] | out_ready[select];
  assign accept   = in_valid & in_ready & ~reset;

  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    if (accept) begin
      valid_d[select]                  = 1'b1;
      data_d[select*WIDTH +: WIDTH]    = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = |valid_q;

`ifdef DEMUX_ACCEPT_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (accept) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign accept_count = count_q;
`else
  assign accept_count = 16'h0000;
`endif

endmodule
